// File: rtl/branch_resolve.sv
// branch_resolve: registered branch-decision stage for the RV32I core.
// Turns ALU comparator flags (EQ/LU/LS of A - B) plus funct3/PC/B-immediate
// into a registered taken/target/illegal/misaligned result behind a
// valid/ready handshake. It also emits a one-cycle fetch flush pulse when a
// clean taken branch leaves the stage.
// Optional feature macro: BRANCH_STATS_EN adds the stat_total/stat_taken
// counters and ports. When it is undefined, the ports and counters do not exist.
module branch_resolve #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            eq,
  input  logic            lu,
  input  logic            ls,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            illegal,
  output logic            misaligned,
  output logic            flush
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_total,
  output logic [31:0]     stat_taken
`endif
);

  // The output register is either empty or holding one resolved branch.
  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic            r_taken;
  logic [XLEN-1:0] r_target;
  logic            r_illegal;
  logic            r_misaligned;
  logic            r_flush;

  logic            w_accept;
  logic            w_drain;
  logic            w_illegal;
  logic            w_cond;
  logic            w_taken;
  logic [XLEN-1:0] w_br_target;
  logic [XLEN-1:0] w_seq_target;
  logic [XLEN-1:0] w_target;
  logic            w_misaligned;
  logic            w_flush_nxt;

  // Branch condition from funct3. The 010/011 encodings never report true.
  function automatic logic f_branch_cond(input logic [2:0] f3,
                                         input logic       f_eq,
                                         input logic       f_lu,
                                         input logic       f_ls);
    logic c;
    c = 1'b0;
    case (f3)
      3'b000:  c = f_eq;
      3'b001:  c = ~f_eq;
      3'b100:  c = f_ls;
      3'b101:  c = ~f_ls;
      3'b110:  c = f_lu;
      3'b111:  c = ~f_lu;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  // funct3 010 and 011 have no branch meaning in RV32I.
  function automatic logic f_is_illegal(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

  assign out_valid  = (r_state == S_FULL);
  assign in_ready   = ~out_valid | out_ready;
  assign taken      = r_taken;
  assign target     = r_target;
  assign illegal    = r_illegal;
  assign misaligned = r_misaligned;
  assign flush      = r_flush;

  // kill squashes both the incoming beat and the handshake of the held one.
  assign w_accept = in_valid & in_ready & ~kill;
  assign w_drain  = out_valid & out_ready & ~kill;

  // Decision and next-PC, computed from the incoming beat.
  // The sums are XLEN wide, so the carry out falls off and the target wraps.
  always_comb begin
    w_illegal    = f_is_illegal(funct3);
    w_cond       = f_branch_cond(funct3, eq, lu, ls);
    w_taken      = w_cond & ~w_illegal;
    w_br_target  = pc + imm;
    w_seq_target = pc + XLEN'(4);
    w_target     = w_taken ? w_br_target : w_seq_target;
    w_misaligned = w_taken & (w_target[1:0] != 2'b00);
  end

  // Valid-bit state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state. kill wins over accept and drain. An accept refills the
  // register even when the consumer drains it in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (kill) begin
      w_state_nxt = S_EMPTY;
    end else if (w_accept) begin
      w_state_nxt = S_FULL;
    end else if (w_drain) begin
      w_state_nxt = S_EMPTY;
    end
  end

  // Result fields load only on accept. A drain leaves their last values in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken      <= 1'b0;
      r_target     <= '0;
      r_illegal    <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (w_accept) begin
      r_taken      <= w_taken;
      r_target     <= w_target;
      r_illegal    <= w_illegal;
      r_misaligned <= w_misaligned;
    end
  end

  // Redirect fetch only when a clean taken branch is handed to the consumer.
  assign w_flush_nxt = w_drain & r_taken & ~r_illegal & ~r_misaligned;

  // Flush pulse: one cycle after the qualifying output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush <= 1'b0;
    end else begin
      r_flush <= w_flush_nxt;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_total;
  logic [31:0] r_stat_taken;

  assign stat_total = r_stat_total;
  assign stat_taken = r_stat_taken;

  // Count legal branches as they leave. Taken ones include misaligned results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_total <= '0;
      r_stat_taken <= '0;
    end else if (w_drain & ~r_illegal) begin
      r_stat_total <= r_stat_total + 32'd1;
      if (r_taken) begin
        r_stat_taken <= r_stat_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve. Stat counters are checked when
// BRANCH_STATS_EN is defined.
module tb_branch_resolve;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic        eq;
  logic        lu;
  logic        ls;
  logic [31:0] pc;
  logic [31:0] imm;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic [31:0] target;
  logic        illegal;
  logic        misaligned;
  logic        flush;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_total;
  logic [31:0] stat_taken;
`endif

  int total;
  int bad;

  branch_resolve #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .funct3     (funct3),
    .eq         (eq),
    .lu         (lu),
    .ls         (ls),
    .pc         (pc),
    .imm        (imm),
    .kill       (kill),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .taken      (taken),
    .target     (target),
    .illegal    (illegal),
    .misaligned (misaligned),
    .flush      (flush)
`ifdef BRANCH_STATS_EN
    ,
    .stat_total (stat_total),
    .stat_taken (stat_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] f3, input logic e, input logic u, input logic s,
                      input logic [31:0] p, input logic [31:0] i);
    in_valid = 1'b1;
    funct3   = f3;
    eq       = e;
    lu       = u;
    ls       = s;
    pc       = p;
    imm      = i;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; funct3 = 3'b000; eq = 1'b0; lu = 1'b0; ls = 1'b0;
    pc = 32'h0; imm = 32'h0; kill = 1'b0; out_ready = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_taken", {31'b0, taken}, 32'd0);
    chk("rst_target", target, 32'h0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'd0);
    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef BRANCH_STATS_EN
    chk("rst_stat_total", stat_total, 32'd0);
    chk("rst_stat_taken", stat_taken, 32'd0);
`endif
    rst_n = 1'b1;

    // BEQ taken: 0x100 + 0x20
    beat(3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20);
    tick();
    chk("beq_valid", {31'b0, out_valid}, 32'd1);
    chk("beq_taken", {31'b0, taken}, 32'd1);
    chk("beq_target", target, 32'h120);
    chk("beq_illegal", {31'b0, illegal}, 32'd0);
    chk("beq_flush_early", {31'b0, flush}, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("beq_flush", {31'b0, flush}, 32'd1);
    chk("beq_drained", {31'b0, out_valid}, 32'd0);
    tick();
    chk("beq_flush_1cyc", {31'b0, flush}, 32'd0);

    // BGEU not taken (lu=1): 0x200 + 4
    beat(3'b111, 1'b0, 1'b1, 1'b0, 32'h200, 32'h40);
    tick();
    chk("bgeu_taken", {31'b0, taken}, 32'd0);
    chk("bgeu_target", target, 32'h204);
    in_valid = 1'b0;
    tick();
    chk("bgeu_flush", {31'b0, flush}, 32'd0);

    // Illegal funct3=010 with eq=1 still not taken
    beat(3'b010, 1'b1, 1'b1, 1'b1, 32'h300, 32'h8);
    tick();
    chk("ill_illegal", {31'b0, illegal}, 32'd1);
    chk("ill_taken", {31'b0, taken}, 32'd0);
    chk("ill_target", target, 32'h304);
    chk("ill_misaligned", {31'b0, misaligned}, 32'd0);
    // BLT taken with wrap: 0xFFFFFFF0 + 0x20
    beat(3'b100, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h20);
    tick();
    chk("ill_no_flush", {31'b0, flush}, 32'd0);
    chk("blt_taken", {31'b0, taken}, 32'd1);
    chk("blt_target_wrap", target, 32'h0000_0010);
    chk("blt_illegal", {31'b0, illegal}, 32'd0);
    // BEQ taken, misaligned: 0x1000 + 0x2
    beat(3'b000, 1'b1, 1'b0, 1'b0, 32'h1000, 32'h2);
    tick();
    chk("blt_flush", {31'b0, flush}, 32'd1);
    chk("mis_target", target, 32'h1002);
    chk("mis_misaligned", {31'b0, misaligned}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("mis_no_flush", {31'b0, flush}, 32'd0);

    // Backpressure: BNE taken 0x400+0x10 held for 3 cycles
    out_ready = 1'b0;
    beat(3'b001, 1'b0, 1'b0, 1'b0, 32'h400, 32'h10);
    tick();
    chk("bp_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_target", target, 32'h410);
    beat(3'b001, 1'b0, 1'b0, 1'b0, 32'h500, 32'h10);
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_target", target, 32'h410);
      chk("bp_hold_taken", {31'b0, taken}, 32'd1);
      chk("bp_hold_flush", {31'b0, flush}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("b2b_target1", target, 32'h510);
    chk("b2b_flush1", {31'b0, flush}, 32'd1);
    // BEQ not taken (eq=0): 0x600 + 4
    beat(3'b000, 1'b0, 1'b0, 1'b0, 32'h600, 32'h10);
    tick();
    chk("b2b_valid2", {31'b0, out_valid}, 32'd1);
    chk("b2b_target2", target, 32'h604);
    chk("b2b_taken2", {31'b0, taken}, 32'd0);
    chk("b2b_flush2", {31'b0, flush}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("b2b_flush3", {31'b0, flush}, 32'd0);
    chk("b2b_empty", {31'b0, out_valid}, 32'd0);

    // Kill a held taken beat and the incoming one together
    out_ready = 1'b0;
    beat(3'b000, 1'b1, 1'b0, 1'b0, 32'h700, 32'h10);
    tick();
    chk("kill_pre_valid", {31'b0, out_valid}, 32'd1);
    kill = 1'b1;
    out_ready = 1'b1;
    beat(3'b000, 1'b1, 1'b0, 1'b0, 32'h800, 32'h10);
    tick();
    chk("kill_valid", {31'b0, out_valid}, 32'd0);
    chk("kill_flush", {31'b0, flush}, 32'd0);
    kill = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("kill_flush_after", {31'b0, flush}, 32'd0);
    chk("kill_still_empty", {31'b0, out_valid}, 32'd0);
`ifdef BRANCH_STATS_EN
    // Legal handshakes so far: 0x120 T, 0x204 N, 0x10 T, 0x1002 T(mis), 0x410 T, 0x510 T, 0x604 N
    chk("stat_total", stat_total, 32'd7);
    chk("stat_taken", stat_taken, 32'd5);
`endif

    // Asynchronous reset with a held result
    out_ready = 1'b0;
    beat(3'b000, 1'b1, 1'b0, 1'b0, 32'h900, 32'h10);
    tick();
    chk("arst_pre_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_taken", {31'b0, taken}, 32'd0);
    chk("arst_target", target, 32'h0);
    chk("arst_flush", {31'b0, flush}, 32'd0);
`ifdef BRANCH_STATS_EN
    chk("arst_stat_total", stat_total, 32'd0);
    chk("arst_stat_taken", stat_taken, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    // BGE taken (ls=0): 0xA00 + 0x40
    beat(3'b101, 1'b0, 1'b0, 1'b0, 32'hA00, 32'h40);
    tick();
    chk("post_rst_valid", {31'b0, out_valid}, 32'd1);
    chk("post_rst_target", target, 32'hA40);
    chk("post_rst_flush", {31'b0, flush}, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("post_rst_flush2", {31'b0, flush}, 32'd1);
`ifdef BRANCH_STATS_EN
    chk("post_rst_stat_total", stat_total, 32'd1);
    chk("post_rst_stat_taken", stat_taken, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Registered branch-decision stage for the RV32I core. Consumes the EQ/LU/LS flags that the ALU comparator produces from A − B, plus the branch funct3, PC and B-immediate. Emits a registered taken/not-taken decision, next-PC target, illegal/misaligned flags and a one-cycle front-end flush pulse. Sits between the execute-stage ALU and the fetch PC mux, with a valid/ready handshake on both sides.

## Interface
- XLEN, 32, datapath width of pc, imm and target
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat this cycle
- funct3  in  3  branch funct3 (B-type)
- eq  in  1  comparator equal flag
- lu  in  1  comparator unsigned less-than flag
- ls  in  1  comparator signed less-than flag
- pc  in  XLEN  PC of the branch instruction
- imm  in  XLEN  sign-extended B-immediate
- kill  in  1  synchronous squash of held and incoming beat
- out_valid  out  1  result register valid
- out_ready  in  1  consumer accepts result
- taken  out  1  branch condition true (0 when illegal)
- target  out  XLEN  next PC
- illegal  out  1  funct3 is 010 or 011
- misaligned  out  1  taken and target[1:0] != 0
- flush  out  1  one-cycle pulse: redirect fetch
- stat_total  out  32  resolved-branch count (BRANCH_STATS_EN only)
- stat_taken  out  32  taken-branch count (BRANCH_STATS_EN only)

## Operation
- Condition by funct3: 000 eq; 001 !eq; 100 ls; 101 !ls; 110 lu; 111 !lu; 010/011 → illegal=1, taken=0.
- target = taken ? (pc + imm) mod 2^XLEN : (pc + 4) mod 2^XLEN. Carry out is discarded; wrap-around is legal.
- misaligned = taken & (target[1:0] != 2'b00). It is computed only for taken branches, so illegal beats never flag misaligned.
- Single output register. in_ready = !out_valid | out_ready, combinational.
- Accept = in_valid & in_ready & !kill. On accept, all result fields load and out_valid←1.
- If out_valid & out_ready and no accept, out_valid←0. The result fields hold their last values.
- kill: out_valid←0 next edge and the same-cycle input beat is discarded. kill takes priority over accept and over output handshake. A killed beat never produces flush or stat updates.
- flush: registered. flush←1 for exactly one cycle after an output handshake (out_valid & out_ready & !kill) with taken=1, illegal=0, misaligned=0. Otherwise flush←0.
- No FSM beyond the valid bit. States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY→FULL on accept.
  - FULL→FULL on accept while the consumer drains the register in the same cycle.
  - FULL→EMPTY on drain without accept, or on kill.

## Timing
- Latency: 1 cycle from accepting edge to out_valid. flush follows the out handshake edge by 1 cycle.
- Throughput: 1 beat/cycle when out_ready is held high.
- in_ready has a combinational path from out_ready. There is no combinational path from in_* to out_*.
- Reset (rst_n low, asynchronous): out_valid=0, taken=0, target=0, illegal=0, misaligned=0, flush=0, stat counters=0.
- Reset asserted mid-transfer drops any held result with no flush. The first accept is possible on the first edge after rst_n deasserts.
- Backpressure: while out_valid & !out_ready, all outputs stay stable and in_ready=0.

## Configuration
- BRANCH_STATS_EN defined: stat_total and stat_taken ports exist.
  - stat_total increments on every output handshake that is not killed and not illegal.
  - stat_taken increments on the same handshakes when taken=1 (misaligned included).
  - Both counters are 32-bit, wrap at 2^32, and reset to 0.
- BRANCH_STATS_EN undefined: ports and counters are absent. Decision and flush behaviour are identical.

## Test plan
- BEQ: funct3=000, eq=1, pc=0x100, imm=0x20, out_ready=1 → next cycle out_valid=1, taken=1, target=0x120. The cycle after that, flush=1 for one cycle.
- BGEU not taken: funct3=111, lu=1, pc=0x200 → taken=0, target=0x204, flush stays 0.
- Illegal and wrap: funct3=010 → illegal=1, taken=0, no flush. Then BLT with ls=1, pc=0xFFFFFFF0, imm=0x20 → target=0x00000010. Then taken with imm=0x2 → misaligned=1, no flush.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. Release → back-to-back beats at 1/cycle.
- Kill: assert kill with out_valid=1 and in_valid=1 in the same cycle → out_valid=0 next cycle, no flush, stats unchanged.
- Stats (macro on): 5 branches (3 taken, 1 illegal, 1 not taken) → stat_total=4, stat_taken=3. Assert rst_n=0 mid-sequence → counters and all outputs read 0 immediately.
